// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: MEM-stage initiator for the 64-word data memory.
// Maps a byte address to a word address, drives the memory write port,
// captures load data and holds the pipeline with freeze until the access
// completes after WAIT_CYCLES extra wait states.
// Optional address checking is enabled by defining MEM_ACCESS_CHECK_EN;
// without it addresses wrap silently and err is tied to 0.
//
// state | meaning
// IDLE  | waiting for a request; freeze follows req_valid
// WAIT  | access in progress; wait counter runs down to 0
// DONE  | one-cycle completion, resp_valid (and err) pulse
module mem_access_ctrl #(
  parameter int WORDLENGTH  = 32,
  parameter int ADDR_BASE   = 1024,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  input  logic                  req_we,
  input  logic [31:0]           req_addr,
  input  logic [WORDLENGTH-1:0] req_wdata,
  output logic                  freeze,
  output logic                  resp_valid,
  output logic [WORDLENGTH-1:0] resp_rdata,
  output logic [5:0]            mem_addr,
  output logic                  mem_wr_en,
  output logic [WORDLENGTH-1:0] mem_wr_data,
  input  logic [WORDLENGTH-1:0] mem_rd_data,
  output logic                  err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [31:0] BASE     = 32'(ADDR_BASE);
  localparam logic [3:0]  CNT_INIT = 4'(WAIT_CYCLES);

  state_t      state;
  logic [3:0]  wait_cnt;
  logic        we_q;
  logic        bad_q;
  logic [31:0] addr_off;
  logic [5:0]  word_addr;
  logic        req_bad;

  // Byte offset from the memory base; the word index wraps every 256 bytes.
  always_comb begin
    addr_off  = req_addr - BASE;
    word_addr = 6'(addr_off >> 2);
  end

`ifdef MEM_ACCESS_CHECK_EN
  // Flag misaligned accesses and anything outside the 256-byte window.
  always_comb begin
    req_bad = (req_addr[1:0] != 2'b00) || (req_addr < BASE) || (addr_off >= 32'd256);
  end
`else
  // No checking: every request is treated as legal.
  always_comb begin
    req_bad = 1'b0;
  end
`endif

  // Pipeline stall: follows the request in IDLE, held for the whole access.
  always_comb begin
    freeze = 1'b0;
    if (!rst) begin
      if (state == IDLE) begin
        freeze = req_valid;
      end else if (state == WAIT) begin
        freeze = 1'b1;
      end
    end
  end

  // Sequencer: latch the request, count wait states, pulse write and response.
  // mem_wr_en is registered one cycle ahead so it is high exactly in the
  // WAIT cycle where the counter reads 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      wait_cnt    <= '0;
      we_q        <= 1'b0;
      bad_q       <= 1'b0;
      resp_valid  <= 1'b0;
      resp_rdata  <= '0;
      mem_addr    <= '0;
      mem_wr_en   <= 1'b0;
      mem_wr_data <= '0;
      err         <= 1'b0;
    end else begin
      resp_valid <= 1'b0;
      err        <= 1'b0;
      mem_wr_en  <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid) begin
            we_q        <= req_we;
            bad_q       <= req_bad;
            mem_addr    <= word_addr;
            mem_wr_data <= req_wdata;
            wait_cnt    <= CNT_INIT;
            mem_wr_en   <= (CNT_INIT == 4'd0) && req_we && !req_bad;
            state       <= WAIT;
          end
        end
        WAIT: begin
          if (wait_cnt == 4'd0) begin
            if (bad_q) begin
              resp_rdata <= '0;
            end else if (!we_q) begin
              resp_rdata <= mem_rd_data;
            end
            resp_valid <= 1'b1;
            err        <= bad_q;
            state      <= DONE;
          end else begin
            wait_cnt  <= wait_cnt - 4'd1;
            mem_wr_en <= (wait_cnt == 4'd1) && we_q && !bad_q;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: two instances (WAIT_CYCLES 2 and 0), each with
// its own memory, checked every cycle against a transaction-level model,
// plus directed scenarios with literal expectations.
`timescale 1ns/1ps
module tb_mem_access_ctrl;
  localparam int W    = 32;
  localparam int BASE = 1024;
  localparam int WC0  = 2;
  localparam int WC1  = 0;
  localparam logic [31:0] BASE_U = 32'd1024;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]   rst;
  logic [1:0]   rv;
  logic [1:0]   rwe;
  logic [31:0]  raddr [2];
  logic [W-1:0] rwd [2];
  logic [1:0]   fz, rvld, wen, er;
  logic [W-1:0] rdat [2];
  logic [5:0]   maddr [2];
  logic [W-1:0] mwd [2];
  logic [W-1:0] mrd [2];
  logic [W-1:0] mem [2][64];

  int n_chk  = 0;
  int n_pass = 0;

  mem_access_ctrl #(.WORDLENGTH(W), .ADDR_BASE(BASE), .WAIT_CYCLES(WC0)) dut0 (
    .clk(clk), .rst(rst[0]), .req_valid(rv[0]), .req_we(rwe[0]), .req_addr(raddr[0]),
    .req_wdata(rwd[0]), .freeze(fz[0]), .resp_valid(rvld[0]), .resp_rdata(rdat[0]),
    .mem_addr(maddr[0]), .mem_wr_en(wen[0]), .mem_wr_data(mwd[0]), .mem_rd_data(mrd[0]),
    .err(er[0]));

  mem_access_ctrl #(.WORDLENGTH(W), .ADDR_BASE(BASE), .WAIT_CYCLES(WC1)) dut1 (
    .clk(clk), .rst(rst[1]), .req_valid(rv[1]), .req_we(rwe[1]), .req_addr(raddr[1]),
    .req_wdata(rwd[1]), .freeze(fz[1]), .resp_valid(rvld[1]), .resp_rdata(rdat[1]),
    .mem_addr(maddr[1]), .mem_wr_en(wen[1]), .mem_wr_data(mwd[1]), .mem_rd_data(mrd[1]),
    .err(er[1]));

  // Memories seen by the two instances
  assign mrd[0] = mem[0][maddr[0]];
  assign mrd[1] = mem[1][maddr[1]];

  always @(posedge clk) begin
    for (int l = 0; l < 2; l++) begin
      if (wen[l]) mem[l][maddr[l]] <= mwd[l];
    end
  end

  task automatic chk(input string name, input int l, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s lane%0d: got %h want %h at %0t", name, l, act, exp, $time);
  endtask

  function automatic logic [5:0] map_word(input logic [31:0] a);
    logic [31:0] off;
    off = a - BASE_U;
    return 6'((off % 32'd256) / 32'd4);
  endfunction

  function automatic logic is_bad(input logic [31:0] a);
`ifdef MEM_ACCESS_CHECK_EN
    return (a % 32'd4 != 32'd0) || (a < BASE_U) || (a - BASE_U >= 32'd256);
`else
    return (a != a);
`endif
  endfunction

  function automatic logic [31:0] init_word(input int i);
    return 32'h12345678 + 32'(i) * 32'h01010101;
  endfunction

  // Reference model: a request seen in cycle 0 occupies cycles 1..wc+1 with
  // freeze, writes in cycle wc+1, responds in cycle wc+2.
  logic        m_busy [2];
  int          m_k    [2];
  logic        m_we   [2];
  logic        m_bad  [2];
  logic [5:0]  m_addr [2];
  logic [31:0] m_wd   [2];
  logic [31:0] m_rd   [2];
  logic [31:0] refmem [2][64];

  always @(negedge clk) begin
    logic e_fz, e_rv, e_we, e_er;
    logic [5:0] e_ma;
    logic [31:0] e_wd, e_rd;
    int wc;
    for (int l = 0; l < 2; l++) begin
      wc = (l == 0) ? WC0 : WC1;
      if (rst[l]) begin
        e_fz = 0; e_rv = 0; e_we = 0; e_er = 0; e_ma = '0; e_wd = '0; e_rd = '0;
        m_busy[l] = 0; m_addr[l] = '0; m_wd[l] = '0; m_rd[l] = '0; m_k[l] = 0;
      end else if (!m_busy[l]) begin
        e_fz = rv[l]; e_rv = 0; e_we = 0; e_er = 0;
        e_ma = m_addr[l]; e_wd = m_wd[l]; e_rd = m_rd[l];
        if (rv[l]) begin
          m_busy[l] = 1; m_k[l] = 1; m_we[l] = rwe[l];
          m_bad[l] = is_bad(raddr[l]); m_addr[l] = map_word(raddr[l]); m_wd[l] = rwd[l];
        end
      end else if (m_k[l] <= wc + 1) begin
        e_fz = 1; e_rv = 0; e_er = 0;
        e_ma = m_addr[l]; e_wd = m_wd[l]; e_rd = m_rd[l];
        e_we = (m_k[l] == wc + 1) && m_we[l] && !m_bad[l];
        if (m_k[l] == wc + 1) begin
          if (m_bad[l]) m_rd[l] = '0;
          else if (m_we[l]) refmem[l][m_addr[l]] = m_wd[l];
          else m_rd[l] = refmem[l][m_addr[l]];
        end
        m_k[l]++;
      end else begin
        e_fz = 0; e_rv = 1; e_we = 0; e_er = m_bad[l];
        e_ma = m_addr[l]; e_wd = m_wd[l]; e_rd = m_rd[l];
        m_busy[l] = 0;
      end
      chk("freeze", l, 32'(fz[l]), 32'(e_fz));
      chk("resp_valid", l, 32'(rvld[l]), 32'(e_rv));
      chk("mem_wr_en", l, 32'(wen[l]), 32'(e_we));
      chk("err", l, 32'(er[l]), 32'(e_er));
      chk("mem_addr", l, 32'(maddr[l]), 32'(e_ma));
      chk("mem_wr_data", l, mwd[l], e_wd);
      chk("resp_rdata", l, rdat[l], e_rd);
    end
  end

  // Per-cycle trace of one directed transaction
  logic [15:0] t_fz, t_rv, t_we, t_er;
  logic [5:0]  t_ma [16];
  logic [31:0] t_wd [16];
  logic [31:0] t_rd [16];

  task automatic run_req(input int l, input logic we, input logic [31:0] a, input logic [31:0] d,
                         input logic [31:0] a2, input logic [31:0] d2,
                         input int hold_n, input int rst_at, input int ncyc);
    @(posedge clk); #1;
    rv[l] = 1'b1; rwe[l] = we; raddr[l] = a; rwd[l] = d;
    t_fz = '0; t_rv = '0; t_we = '0; t_er = '0;
    for (int c = 0; c < ncyc; c++) begin
      @(negedge clk);
      t_fz[c] = fz[l]; t_rv[c] = rvld[l]; t_we[c] = wen[l]; t_er[c] = er[l];
      t_ma[c] = maddr[l]; t_wd[c] = mwd[l]; t_rd[c] = rdat[l];
      @(posedge clk); #1;
      if (c == 0) begin raddr[l] = a2; rwd[l] = d2; end
      if (c + 1 == hold_n) rv[l] = 1'b0;
      if (c + 1 == rst_at) rst[l] = 1'b1;
      if (c == rst_at) rst[l] = 1'b0;
    end
  endtask

  function automatic logic [31:0] pick_addr();
    int s;
    s = $urandom_range(0, 7);
    if (s < 5) return 32'(BASE + 4 * $urandom_range(0, 63));
    else if (s == 5) return 32'(BASE + $urandom_range(0, 255));
    else if (s == 6) return 32'(BASE + 256 + $urandom_range(0, 511));
    else return $urandom();
  endfunction

  initial begin
    rst = 2'b11; rv = '0; rwe = '0;
    for (int l = 0; l < 2; l++) begin
      raddr[l] = '0; rwd[l] = '0;
      for (int i = 0; i < 64; i++) begin
        mem[l][i] = init_word(i);
        refmem[l][i] = init_word(i);
      end
    end
    repeat (3) @(posedge clk);
    #1 rst = 2'b00;

    // Store 0xDEADBEEF at 1032 then load it back (WAIT_CYCLES=2)
    run_req(0, 1'b1, 32'd1032, 32'hDEADBEEF, 32'd1032, 32'hDEADBEEF, 1, -1, 6);
    chk("st_freeze_pattern", 0, 32'(t_fz[5:0]), 32'h0F);
    chk("st_resp_pattern", 0, 32'(t_rv[5:0]), 32'h10);
    chk("st_wr_en_pattern", 0, 32'(t_we[5:0]), 32'h08);
    chk("st_mem_addr", 0, 32'(t_ma[3]), 32'd2);
    chk("st_mem_wr_data", 0, t_wd[3], 32'hDEADBEEF);
    run_req(0, 1'b0, 32'd1032, 32'h0, 32'd1032, 32'h0, 1, -1, 6);
    chk("ld_resp_pattern", 0, 32'(t_rv[5:0]), 32'h10);
    chk("ld_rdata", 0, t_rd[4], 32'hDEADBEEF);

    // WAIT_CYCLES=0 load of word 0
    run_req(1, 1'b0, 32'd1024, 32'h0, 32'd1024, 32'h0, 1, -1, 6);
    chk("wc0_freeze_pattern", 1, 32'(t_fz[5:0]), 32'h03);
    chk("wc0_resp_pattern", 1, 32'(t_rv[5:0]), 32'h04);
    chk("wc0_rdata", 1, t_rd[2], 32'h12345678);

    // Back-to-back stores to 1028 and 1036 with req_valid held
    run_req(0, 1'b1, 32'd1028, 32'h11111111, 32'd1036, 32'h33333333, 6, -1, 12);
    chk("b2b_freeze_pattern", 0, 32'(t_fz[11:0]), 32'h1EF);
    chk("b2b_wr_en_pattern", 0, 32'(t_we[11:0]), 32'h108);
    chk("b2b_resp_pattern", 0, 32'(t_rv[11:0]), 32'h210);
    chk("b2b_addr_first", 0, 32'(t_ma[3]), 32'd1);
    chk("b2b_addr_second", 0, 32'(t_ma[8]), 32'd3);
    chk("b2b_data_second", 0, t_wd[8], 32'h33333333);

    // Reset in cycle 2 of a store to 1040
    run_req(0, 1'b1, 32'd1040, 32'h0BADF00D, 32'd1040, 32'h0BADF00D, 1, 2, 6);
    chk("rst_wr_en_pattern", 0, 32'(t_we[5:0]), 32'h00);
    chk("rst_resp_pattern", 0, 32'(t_rv[5:0]), 32'h00);
    chk("rst_freeze", 0, 32'(t_fz[2]), 32'd0);
    chk("rst_mem_addr", 0, 32'(t_ma[2]), 32'd0);
    chk("rst_mem_wr_data", 0, t_wd[2], 32'd0);
    chk("rst_rdata", 0, t_rd[2], 32'd0);
    run_req(0, 1'b0, 32'd1040, 32'h0, 32'd1040, 32'h0, 1, -1, 6);
    chk("rst_old_contents", 0, t_rd[4], 32'h16385A7C);

`ifdef MEM_ACCESS_CHECK_EN
    run_req(0, 1'b1, 32'd1026, 32'hAAAA5555, 32'd1026, 32'hAAAA5555, 1, -1, 6);
    chk("chk_unaligned_wr_en", 0, 32'(t_we[5:0]), 32'h00);
    chk("chk_unaligned_resp", 0, 32'(t_rv[5:0]), 32'h10);
    chk("chk_unaligned_err", 0, 32'(t_er[5:0]), 32'h10);
    run_req(0, 1'b0, 32'd1280, 32'h0, 32'd1280, 32'h0, 1, -1, 6);
    chk("chk_range_rdata", 0, t_rd[4], 32'd0);
    chk("chk_range_err", 0, 32'(t_er[4]), 32'd1);
`else
    // Wrap: 1284 lands on word 1
    run_req(1, 1'b1, 32'd1284, 32'hCAFEF00D, 32'd1284, 32'hCAFEF00D, 1, -1, 6);
    chk("wrap_wr_en_pattern", 1, 32'(t_we[5:0]), 32'h02);
    chk("wrap_mem_addr", 1, 32'(t_ma[1]), 32'd1);
    run_req(1, 1'b0, 32'd1028, 32'h0, 32'd1028, 32'h0, 1, -1, 6);
    chk("wrap_readback", 1, t_rd[2], 32'hCAFEF00D);
    chk("wrap_err", 1, 32'(t_er[5:0]), 32'h00);
`endif

    // Randomized traffic on both lanes, with occasional resets
    for (int i = 0; i < 4000; i++) begin
      @(posedge clk); #1;
      for (int l = 0; l < 2; l++) begin
        if (rst[l]) rst[l] = 1'b0;
        else if ($urandom_range(0, 299) == 0) rst[l] = 1'b1;
        if ($urandom_range(0, 3) != 0) begin
          rv[l]    = ($urandom_range(0, 9) < 6);
          rwe[l]   = 1'($urandom_range(0, 1));
          raddr[l] = pick_addr();
          rwd[l]   = $urandom();
        end
      end
    end
    @(posedge clk); #1;
    rv = '0; rst = '0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
- Initiator side of the 64-word data memory interface, in the MEM stage of the ARM pipeline.
- Accepts one load/store request per instruction from the pipeline using a byte address.
- Drives the memory's word address, write enable and write data; captures read data.
- Holds the pipeline with freeze until the access completes after a programmable number of wait states.

Parameters:
- WORDLENGTH, 32, data width of the pipeline and memory.
- ADDR_BASE, 1024, byte address that maps to memory word 0.
- WAIT_CYCLES, 2, extra access wait states; legal range 0..15.

Ports:
- clk  input  1  clock
- rst  input  1  reset
- req_valid  input  1  MEM-stage instruction is a load or store
- req_we  input  1  1 = store, 0 = load
- req_addr  input  32  byte address from the ALU
- req_wdata  input  WORDLENGTH  store data
- freeze  output  1  stall the pipeline
- resp_valid  output  1  one-cycle completion pulse
- resp_rdata  output  WORDLENGTH  load result, registered
- mem_addr  output  6  memory word address
- mem_wr_en  output  1  memory write enable
- mem_wr_data  output  WORDLENGTH  memory write data
- mem_rd_data  input  WORDLENGTH  memory combinational read data
- err  output  1  access error (see Optional Feature)

Behaviour:
- Reset: rst is asynchronous, active-high; clock is clk. On reset, state = IDLE and all registers clear.
- Outputs during and after reset are 0: freeze, resp_valid, resp_rdata, mem_addr, mem_wr_en, mem_wr_data, err.
- Address mapping: word = (req_addr - ADDR_BASE) >> 2, truncated to 6 bits, so offsets wrap modulo 256 bytes.
- The subtraction is 32-bit unsigned.
- IDLE state:
  - freeze = req_valid (combinational).
  - On req_valid: latch req_we, the mapped word address and req_wdata into the mem_* registers.
  - Load the wait counter with WAIT_CYCLES and go to WAIT.
- WAIT state:
  - freeze = 1.
  - The counter decrements each cycle.
  - When counter == 0:
    - mem_wr_en = latched req_we for exactly this cycle.
    - resp_rdata <= mem_rd_data on loads only; stores leave resp_rdata unchanged.
    - Go to DONE.
- DONE state:
  - freeze = 0, resp_valid = 1 for one cycle.
  - req_valid is ignored this cycle; the next instruction's request is sampled in IDLE on the following cycle.
  - Go to IDLE.
- Latency: for a request first seen in cycle 0, freeze is high in cycles 0..WAIT_CYCLES+1 and resp_valid is high in cycle WAIT_CYCLES+2.
  - WAIT_CYCLES=0 gives a 1-cycle WAIT and resp_valid in cycle 2.
- mem_wr_en is never asserted outside the final WAIT cycle and never more than once per request.
- mem_addr and mem_wr_data hold their last latched value while in IDLE.
- resp_rdata holds its value until the next load completes.
- Request changes: changes on req_* after the IDLE latch cycle are ignored until the return to IDLE.
- Reset mid-operation: return immediately to IDLE.
  - If rst asserts before the final WAIT edge, no write occurs.
  - The pending response is discarded, with no resp_valid.
- Back-to-back requests: each request is served in turn, with a one-cycle IDLE gap between DONE and the next latch.

Optional Feature:
- Macro: MEM_ACCESS_CHECK_EN.
- With the macro: in IDLE, a request is flagged as an error if any of these hold:
  - req_addr[1:0] != 0
  - req_addr < ADDR_BASE
  - req_addr - ADDR_BASE >= 256
- Behaviour for a flagged request:
  - Sequencing and timing are identical to a normal request.
  - mem_wr_en stays 0 and resp_rdata is forced to 0.
  - err pulses together with resp_valid in DONE.
- Without the macro:
  - No checking; addresses are silently truncated and wrap.
  - err is tied to 0.

Test Plan:
- Store then load, WAIT_CYCLES=2: store 0xDEADBEEF at 1032 (word 2).
  - Store: mem_wr_en high in cycle 3 only with mem_addr=2; freeze high in cycles 0..3; resp_valid in cycle 4.
  - Load of 1032: resp_rdata=0xDEADBEEF in its DONE cycle.
- WAIT_CYCLES=0, load from 1024 with memory word 0 = 0x12345678: freeze high in cycles 0..1; resp_valid in cycle 2; resp_rdata=0x12345678.
- Back-to-back stores to 1028 and 1036 with req_valid held high:
  - Two distinct mem_wr_en pulses, at mem_addr 1 then 3.
  - One-cycle freeze-low gap in DONE between them.
- Reset mid-operation: assert rst in cycle 2 of a store to 1040 with WAIT_CYCLES=2.
  - No mem_wr_en pulse, no resp_valid.
  - All outputs 0; a following load of 1040 returns the old contents.
- Wrap: a store to 1024+256+4 = 1284 (without MEM_ACCESS_CHECK_EN) writes mem_addr=1.
- With MEM_ACCESS_CHECK_EN:
  - A store to 1026: no mem_wr_en; err=1 and resp_valid=1 in the same cycle.
  - A load of 1280: resp_rdata=0, err=1.
